// File: rtl/led_seg_scan_ctrl_pkg.sv
// led_seg_scan_ctrl_pkg: segment bit positions, hex-to-7-segment table and slot phase type
package led_seg_scan_ctrl_pkg;
  localparam int SEG_A = 0;
  localparam int SEG_G = 6;
  localparam int SEG_DP = 7;
  localparam logic [15:0][6:0] HEX7 = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  typedef enum logic [1:0] {PH_DEAD, PH_LIT, PH_DARK} phase_e;
endpackage

// File: rtl/led_seg_scan_ctrl_if.sv
// led_seg_scan_ctrl_if: display-data inputs and LED pin outputs of the scan controller
interface led_seg_scan_ctrl_if #(
  parameter int DIGITS = 8,
  parameter int PWM_BITS = 4
);
  logic [4*DIGITS-1:0] digits_in;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   blank_in;
  logic [PWM_BITS-1:0] brightness;
  logic                update;
  logic [7:0]          seg_data;
  logic [DIGITS-1:0]   seg_sel;
  logic                frame_done;
  modport master (
    output digits_in, dp_in, blank_in, brightness, update,
    input  seg_data, seg_sel, frame_done
  );
  modport slave (
    input  digits_in, dp_in, blank_in, brightness, update,
    output seg_data, seg_sel, frame_done
  );
endinterface

// File: rtl/led_seg_scan_ctrl_seg_decoder.sv
// seg_decoder: 4-bit binary to active-high 7-segment pattern {g..a}
module seg_decoder
  import led_seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] bin_i,
  output logic [6:0] seg_o
);
  assign seg_o = HEX7[bin_i];
endmodule

// File: rtl/led_seg_scan_ctrl.sv
// led_seg_scan_ctrl: double-buffered multiplexed 7-segment scanner with dead time and PWM dimming
module led_seg_scan_ctrl
  import led_seg_scan_ctrl_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int SCAN_DIV = 1024,
  parameter int DEAD_CYCLES = 16,
  parameter int PWM_BITS = 4,
  parameter int SEL_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input logic clk,
  input logic rst,
  led_seg_scan_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic SEL_INV = SEL_ACTIVE_LOW != 0;
  localparam logic SEG_INV = SEG_ACTIVE_LOW != 0;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic pending_q, pending_d;
  logic [DIGITS-1:0][3:0] stg_dig_q, stg_dig_d, sh_dig_q, sh_dig_d;
  logic [DIGITS-1:0] stg_dp_q, stg_dp_d, stg_blank_q, stg_blank_d;
  logic [DIGITS-1:0] sh_dp_q, sh_dp_d, sh_blank_q, sh_blank_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic [7:0] data_q, data_d, data_raw;
  logic fd_q, fd_d, slot_end, boundary, lit;
  logic [6:0] seg;
  phase_e phase;

  seg_decoder u_dec (.bin_i(sh_dig_q[idx_q]), .seg_o(seg));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      pending_q <= 1'b0;
      stg_dig_q <= '0;
      stg_dp_q <= '0;
      stg_blank_q <= '0;
      sh_dig_q <= '0;
      sh_dp_q <= '0;
      sh_blank_q <= '1;
      sel_q <= {DIGITS{SEL_INV}};
      data_q <= {8{SEG_INV}};
      fd_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      pending_q <= pending_d;
      stg_dig_q <= stg_dig_d;
      stg_dp_q <= stg_dp_d;
      stg_blank_q <= stg_blank_d;
      sh_dig_q <= sh_dig_d;
      sh_dp_q <= sh_dp_d;
      sh_blank_q <= sh_blank_d;
      sel_q <= sel_d;
      data_q <= data_d;
      fd_q <= fd_d;
    end
  end

  always_comb begin
    slot_end = cnt_q == CNT_W'(SCAN_DIV - 1);
    boundary = slot_end && idx_q == IDX_W'(DIGITS - 1);
    cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d = !slot_end ? idx_q : boundary ? '0 : idx_q + IDX_W'(1);
    phase = cnt_q < CNT_W'(DEAD_CYCLES) ? PH_DEAD :
            cnt_q[PWM_BITS-1:0] < bus.brightness ? PH_LIT : PH_DARK;
    // an update landing on the boundary bypasses staging and goes straight to the shadow
    {stg_dig_d, stg_dp_d, stg_blank_d} = bus.update && !boundary ?
      {bus.digits_in, bus.dp_in, bus.blank_in} : {stg_dig_q, stg_dp_q, stg_blank_q};
    {sh_dig_d, sh_dp_d, sh_blank_d} = !boundary ? {sh_dig_q, sh_dp_q, sh_blank_q} :
      bus.update ? {bus.digits_in, bus.dp_in, bus.blank_in} :
      pending_q ? {stg_dig_q, stg_dp_q, stg_blank_q} : {sh_dig_q, sh_dp_q, sh_blank_q};
    pending_d = boundary ? 1'b0 : pending_q | bus.update;
    lit = phase == PH_LIT && !sh_blank_q[idx_q];
    data_raw = '0;
    data_raw[SEG_G:SEG_A] = seg;
    data_raw[SEG_DP] = sh_dp_q[idx_q];
    sel_d = (lit ? DIGITS'(1) << idx_q : '0) ^ {DIGITS{SEL_INV}};
    data_d = (lit ? data_raw : 8'h00) ^ {8{SEG_INV}};
    fd_d = boundary;
  end

  assign bus.seg_sel = sel_q;
  assign bus.seg_data = data_q;
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_led_seg_scan_ctrl.sv
// tb_led_seg_scan_ctrl: directed and randomized checks against a frame-time reference model
module tb_led_seg_scan_ctrl;
  localparam int D = 4, S = 16, DC = 2, P = 2, F = D * S;
  logic clk = 1'b0, rst = 1'b1;
  int vecs = 0, errs = 0, t = 0, first_fd = -1;
  logic [15:0] m_dig = '0, s_dig = '0;
  logic [3:0] m_dp = '0, m_blank = '1, s_dp = '0, s_blank = '0;
  bit s_valid = 1'b0;
  logic [6:0] hex7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  led_seg_scan_ctrl_if #(.DIGITS(D), .PWM_BITS(P)) bus ();

  led_seg_scan_ctrl #(
    .DIGITS(D), .SCAN_DIV(S), .DEAD_CYCLES(DC), .PWM_BITS(P),
    .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict the pins from the frame position, then advance the model and compare.
  task automatic cyc();
    int pos = t % F;
    int dg = pos / S;
    int c = pos % S;
    bit lit = !rst && c >= DC && (c % (1 << P)) < int'(bus.brightness) && !m_blank[dg];
    logic [3:0] e_sel = lit ? ~(4'b0001 << dg) : 4'hF;
    logic [7:0] e_data = lit ? {m_dp[dg], hex7[m_dig[dg*4 +: 4]]} : 8'h00;
    bit e_fd = !rst && pos == F - 1;
    if (rst) begin
      t = 0; m_dig = '0; m_dp = '0; m_blank = '1; s_valid = 0; first_fd = -1;
    end else begin
      if (pos == F - 1) begin
        if (bus.update) {m_dig, m_dp, m_blank} = {bus.digits_in, bus.dp_in, bus.blank_in};
        else if (s_valid) {m_dig, m_dp, m_blank} = {s_dig, s_dp, s_blank};
        s_valid = 0;
      end else if (bus.update) begin
        {s_dig, s_dp, s_blank} = {bus.digits_in, bus.dp_in, bus.blank_in};
        s_valid = 1;
      end
      t++;
    end
    @(posedge clk);
    #1;
    chk("seg_sel", 32'(bus.seg_sel), 32'(e_sel));
    chk("seg_data", 32'(bus.seg_data), 32'(e_data));
    chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
    if (bus.frame_done && first_fd < 0) first_fd = t;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run_to(input int p);
    for (int i = 0; i < F && t % F != p; i++) cyc();
  endtask

  task automatic upd(input logic [15:0] dg, input logic [3:0] dp, input logic [3:0] bl);
    bus.digits_in = dg; bus.dp_in = dp; bus.blank_in = bl; bus.update = 1'b1;
    cyc();
    bus.update = 1'b0;
  endtask

  initial begin
    bus.digits_in = '0; bus.dp_in = '0; bus.blank_in = '0; bus.update = 1'b0;
    bus.brightness = 2'd3;
    run(3);
    chk("reset_sel", 32'(bus.seg_sel), 32'hF);
    chk("reset_data", 32'(bus.seg_data), 32'h0);
    rst = 1'b0;
    run(F);
    chk("first_frame_done", 32'(first_fd), 32'd64);
    run_to(10);
    upd(16'h4321, 4'b0010, 4'b0000);
    run_to(0);
    run_to(3);
    chk("slot0_data", 32'(bus.seg_data), 32'h06);
    chk("slot0_sel", 32'(bus.seg_sel), 32'b1110);
    run_to(22);
    chk("slot1_data", 32'(bus.seg_data), 32'hDB);
    chk("slot1_sel", 32'(bus.seg_sel), 32'b1101);
    run_to(24);
    chk("pwm_gap_sel", 32'(bus.seg_sel), 32'hF);
    run_to(38);
    chk("slot2_data", 32'(bus.seg_data), 32'h4F);
    run_to(54);
    chk("slot3_data", 32'(bus.seg_data), 32'h66);
    chk("slot3_sel", 32'(bus.seg_sel), 32'b0111);
    run_to(20);
    upd(16'($urandom), 4'($urandom), 4'b0000);
    run_to(40);
    upd(16'($urandom), 4'($urandom), 4'b0000);
    run_to(0);
    run(F);
    run_to(F - 1);
    upd(16'($urandom), 4'($urandom), 4'b0000);
    run(F);
    bus.brightness = 2'd0;
    run(F);
    bus.brightness = 2'd3;
    run_to(5);
    upd(16'($urandom), 4'($urandom), 4'b0100);
    run_to(0);
    run(F);
    for (int i = 0; i < 400; i++) begin
      bus.brightness = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) upd(16'($urandom), 4'($urandom), 4'($urandom));
      else cyc();
    end
    bus.brightness = 2'd3;
    run_to(0);
    run_to(30);
    upd(16'($urandom), 4'($urandom), 4'b0000);
    run_to(40);
    rst = 1'b1;
    bus.digits_in = 16'($urandom); bus.blank_in = 4'b0000; bus.update = 1'b1;
    cyc();
    chk("rst_mid_sel", 32'(bus.seg_sel), 32'hF);
    chk("rst_mid_data", 32'(bus.seg_data), 32'h0);
    rst = 1'b0;
    bus.update = 1'b0;
    run(2 * F);
    chk("restart_frame_done", 32'(first_fd), 32'd64);
    upd(16'($urandom), 4'($urandom), 4'b0000);
    run(2 * F);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
